// File: rtl/bus_dev_port.sv
// Purpose: per-slot bus endpoint; host TX FIFO toward the bus and a destination-filtered RX FIFO back to the host.
// Latency: a host write raises pndng one cycle later, and an accepted push raises rx_vld one cycle later; both heads are fall-through.
// Backpressure: a full FIFO drops new writes and sets a sticky overflow flag, unless that FIFO is read in the same cycle.

// Generic circular FIFO: fall-through head, registered count, drop pulse on a rejected write.
module bus_dev_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr,
  input  logic [W-1:0]             wdat,
  input  logic                     rd,
  output logic [W-1:0]             rdat,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic                     full,
  output logic                     nempty,
  output logic                     drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  assign nempty = (cnt != '0);
  assign full   = (cnt == CW'(DEPTH));
  // A read on an empty FIFO is ignored. A write into a full FIFO is still
  // accepted when a read frees a slot in the same cycle.
  assign rd_ok  = rd && nempty;
  assign wr_ok  = wr && (!full || rd_ok);
  assign drop   = wr && !wr_ok;
  assign rdat   = nempty ? mem[rd_ptr] : '0;

  // Storage array; contents need no reset because the head is gated by nempty.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok) mem[wr_ptr] <= wdat;
  end

  // Pointers wrap naturally (power-of-two depth); the count tracks the net change.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// Device endpoint: one instance per bus slot.
module bus_dev_port #(
  parameter int         pckg_sz   = 16,
  parameter int         depth     = 8,
  parameter logic [7:0] dev_id    = 8'd0,
  parameter logic [7:0] broadcast = {8{1'b1}}
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [pckg_sz-1:0]       wr_data,
  output logic                     tx_full,
  output logic [$clog2(depth):0]   tx_cnt,
  output logic                     tx_ovf,
  output logic                     pndng,
  output logic [pckg_sz-1:0]       D_pop,
  input  logic                     pop,
  input  logic                     push,
  input  logic [pckg_sz-1:0]       D_push,
  input  logic                     rd_en,
  output logic [pckg_sz-1:0]       rd_data,
  output logic                     rx_vld,
  output logic [$clog2(depth):0]   rx_cnt,
  output logic                     rx_ovf,
  output logic [7:0]               misroute_cnt
);
  logic       tx_drop;
  logic       rx_drop;
  logic       rx_full;
  logic [7:0] dest;
  logic       accept;

  assign dest   = D_push[pckg_sz-1 -: 8];
  assign accept = (dest == dev_id) || (dest == broadcast);

  bus_dev_fifo #(.W(pckg_sz), .DEPTH(depth)) u_tx (
    .clk    (clk),
    .reset  (reset),
    .wr     (wr_en),
    .wdat   (wr_data),
    .rd     (pop),
    .rdat   (D_pop),
    .cnt    (tx_cnt),
    .full   (tx_full),
    .nempty (pndng),
    .drop   (tx_drop)
  );

  bus_dev_fifo #(.W(pckg_sz), .DEPTH(depth)) u_rx (
    .clk    (clk),
    .reset  (reset),
    .wr     (push && accept),
    .wdat   (D_push),
    .rd     (rd_en),
    .rdat   (rd_data),
    .cnt    (rx_cnt),
    .full   (rx_full),
    .nempty (rx_vld),
    .drop   (rx_drop)
  );

  // Sticky overflow flags; cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_ovf <= 1'b0;
      rx_ovf <= 1'b0;
    end else begin
      if (tx_drop) tx_ovf <= 1'b1;
      if (rx_drop) rx_ovf <= 1'b1;
    end
  end

  // Count deliveries addressed to someone else, saturating at 255.
  always_ff @(posedge clk) begin
    if (reset) begin
      misroute_cnt <= 8'd0;
    end else if (push && !accept && (misroute_cnt != 8'hFF)) begin
      misroute_cnt <= misroute_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_bus_dev_port.sv
// Directed testbench for bus_dev_port (dev_id=2, depth=8, 16-bit packets).
// Inputs change 1ns after a rising edge; outputs are checked at the same point.
module tb_bus_dev_port;
  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        tx_full;
  logic [3:0]  tx_cnt;
  logic        tx_ovf;
  logic        pndng;
  logic [15:0] D_pop;
  logic        pop;
  logic        push;
  logic [15:0] D_push;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        rx_vld;
  logic [3:0]  rx_cnt;
  logic        rx_ovf;
  logic [7:0]  misroute_cnt;

  int tests = 0;
  int errs  = 0;

  always #5 clk = ~clk;

  bus_dev_port #(.pckg_sz(16), .depth(8), .dev_id(8'd2)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .tx_full      (tx_full),
    .tx_cnt       (tx_cnt),
    .tx_ovf       (tx_ovf),
    .pndng        (pndng),
    .D_pop        (D_pop),
    .pop          (pop),
    .push         (push),
    .D_push       (D_push),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rx_vld       (rx_vld),
    .rx_cnt       (rx_cnt),
    .rx_ovf       (rx_ovf),
    .misroute_cnt (misroute_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 0; pop = 0; push = 0; rd_en = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic check_clear(input string tag);
    chk({tag, " pndng"},   32'(pndng), 0);
    chk({tag, " D_pop"},   32'(D_pop), 0);
    chk({tag, " tx_full"}, 32'(tx_full), 0);
    chk({tag, " tx_cnt"},  32'(tx_cnt), 0);
    chk({tag, " tx_ovf"},  32'(tx_ovf), 0);
    chk({tag, " rx_vld"},  32'(rx_vld), 0);
    chk({tag, " rd_data"}, 32'(rd_data), 0);
    chk({tag, " rx_cnt"},  32'(rx_cnt), 0);
    chk({tag, " rx_ovf"},  32'(rx_ovf), 0);
    chk({tag, " misroute"}, 32'(misroute_cnt), 0);
  endtask

  initial begin
    idle();
    wr_data = 0; D_push = 0;
    reset = 1;
    tick();
    tick();
    reset = 0;
    check_clear("reset");

    // Two writes, then two pops.
    wr_en = 1; wr_data = 16'h0311; tick();
    chk("t1 pndng", 32'(pndng), 1);
    chk("t1 head0", 32'(D_pop), 32'h0311);
    wr_data = 16'h0322; tick(); wr_en = 0;
    chk("t1 cnt2", 32'(tx_cnt), 2);
    chk("t1 head stable", 32'(D_pop), 32'h0311);
    pop = 1; tick(); pop = 0;
    chk("t1 head1", 32'(D_pop), 32'h0322);
    chk("t1 cnt1", 32'(tx_cnt), 1);
    pop = 1; tick(); pop = 0;
    chk("t1 pndng0", 32'(pndng), 0);
    chk("t1 D_pop0", 32'(D_pop), 0);
    pop = 1; tick(); pop = 0;
    chk("t1 empty pop cnt", 32'(tx_cnt), 0);

    // Nine writes into an 8-deep TX FIFO, pointers wrap.
    for (int i = 0; i < 9; i++) begin
      wr_en = 1; wr_data = 16'h0400 + 16'(i); tick();
      if (i == 6) chk("t2 not full at 7", 32'(tx_full), 0);
      if (i == 7) chk("t2 full at 8", 32'(tx_full), 1);
    end
    wr_en = 0;
    chk("t2 ovf", 32'(tx_ovf), 1);
    chk("t2 cnt8", 32'(tx_cnt), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2 drain%0d", i), 32'(D_pop), 32'h0400 + 32'(i));
      pop = 1; tick(); pop = 0;
    end
    chk("t2 empty", 32'(pndng), 0);

    // Full TX with a same-cycle write and pop.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1; wr_data = 16'h0500 + 16'(i); tick();
    end
    wr_data = 16'h01AA; pop = 1; tick(); idle();
    chk("t3 cnt8", 32'(tx_cnt), 8);
    chk("t3 no ovf", 32'(tx_ovf), 0);
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("t3 drain%0d", i), 32'(D_pop), 32'h0500 + 32'(i));
      pop = 1; tick(); pop = 0;
    end
    chk("t3 last", 32'(D_pop), 32'h01AA);
    pop = 1; tick(); pop = 0;
    chk("t3 empty", 32'(tx_cnt), 0);

    // RX destination filter.
    push = 1; D_push = 16'h0255; tick();
    chk("t4 rx_vld lat", 32'(rx_vld), 1);
    D_push = 16'hFF66; tick();
    D_push = 16'h0377; tick(); push = 0;
    chk("t4 rx_cnt", 32'(rx_cnt), 2);
    chk("t4 misroute", 32'(misroute_cnt), 1);
    chk("t4 head0", 32'(rd_data), 32'h0255);
    rd_en = 1; tick(); rd_en = 0;
    chk("t4 head1", 32'(rd_data), 32'hFF66);
    rd_en = 1; tick(); rd_en = 0;
    chk("t4 rx empty", 32'(rx_vld), 0);
    chk("t4 rd_data0", 32'(rd_data), 0);
    rd_en = 1; tick(); rd_en = 0;
    chk("t4 empty rd cnt", 32'(rx_cnt), 0);

    // Misroute counter saturation.
    push = 1; D_push = 16'h0999;
    for (int i = 0; i < 260; i++) tick();
    push = 0;
    chk("t4 misroute sat", 32'(misroute_cnt), 255);
    chk("t4 misroute no store", 32'(rx_cnt), 0);

    // RX overflow, then the same with a read alongside the 9th push.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push = 1; D_push = 16'h0200 + 16'(i); tick();
    end
    D_push = 16'h02AA; tick(); push = 0;
    chk("t5 ovf", 32'(rx_ovf), 1);
    chk("t5 cnt8", 32'(rx_cnt), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t5 drain%0d", i), 32'(rd_data), 32'h0200 + 32'(i));
      rd_en = 1; tick(); rd_en = 0;
    end
    chk("t5 empty", 32'(rx_vld), 0);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push = 1; D_push = 16'hFF00 + 16'(i); tick();
    end
    D_push = 16'h02BB; rd_en = 1; tick(); idle();
    chk("t5b no ovf", 32'(rx_ovf), 0);
    chk("t5b cnt8", 32'(rx_cnt), 8);
    for (int i = 1; i < 8; i++) begin
      rd_en = 1; tick(); rd_en = 0;
    end
    chk("t5b last", 32'(rd_data), 32'h02BB);

    // Mid-operation reset, with simultaneous TX and RX traffic beforehand.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1; wr_data = 16'h0600 + 16'(i);
      push = (i != 4); D_push = (i == 3) ? 16'h0700 : 16'h0200 + 16'(i);
      pop = (i == 2);
      tick();
    end
    idle();
    chk("t6 tx_cnt", 32'(tx_cnt), 4);
    chk("t6 rx_cnt", 32'(rx_cnt), 3);
    chk("t6 misroute", 32'(misroute_cnt), 1);
    chk("t6 head", 32'(D_pop), 32'h0601);
    wr_en = 1; wr_data = 16'h0605; tick(); wr_en = 0;
    chk("t6 tx_cnt5", 32'(tx_cnt), 5);
    reset = 1; wr_en = 1; pop = 1; push = 1; rd_en = 1; wr_data = 16'h0ABC; D_push = 16'h0222;
    tick();
    reset = 0; idle();
    check_clear("t6 after reset");
    wr_en = 1; wr_data = 16'h0333; tick(); wr_en = 0;
    chk("t6 pndng", 32'(pndng), 1);
    chk("t6 D_pop", 32'(D_pop), 32'h0333);
    chk("t6 tx_cnt1", 32'(tx_cnt), 1);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule

// File: doc/bus_dev_port.md
Name: bus_dev_port

Overview:
- Per-device endpoint that sits directly on one device slot of bs_gnrtr_n_rbtr.
- TX side: the local host writes packets into a FIFO. The block presents them to the bus as pndng/D_pop and retires the head on the bus's pop.
- RX side: captures bus push/D_push deliveries into a FIFO for the host to read. Filters by destination ID and flags misrouted packets.
- One instance per drvrs slot; with bits>1, one instance per (bit, slot) pair.

Parameters:
- pckg_sz, 16, packet width in bits; bits [pckg_sz-1 -: 8] carry the destination ID, the rest is payload.
- depth, 8, entries per FIFO (TX and RX), power of two, >=2.
- dev_id, 0, 8-bit ID of this device.
- broadcast, {8{1'b1}}, destination ID accepted by every device.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  host write strobe to TX FIFO.
- wr_data  in  pckg_sz  host packet to transmit.
- tx_full  out  1  TX FIFO holds depth entries.
- tx_cnt  out  $clog2(depth)+1  TX occupancy.
- tx_ovf  out  1  sticky: host write dropped because TX was full.
- pndng  out  1  to bus: TX FIFO non-empty.
- D_pop  out  pckg_sz  to bus: TX head entry (first-word fall-through).
- pop  in  1  from bus: consume TX head.
- push  in  1  from bus: deliver D_push to this device.
- D_push  in  pckg_sz  from bus: delivered packet.
- rd_en  in  1  host read strobe on RX FIFO.
- rd_data  out  pckg_sz  RX head entry (first-word fall-through).
- rx_vld  out  1  RX FIFO non-empty.
- rx_cnt  out  $clog2(depth)+1  RX occupancy.
- rx_ovf  out  1  sticky: accepted delivery dropped because RX was full.
- misroute_cnt  out  8  deliveries whose ID was neither dev_id nor broadcast; saturates at 255.

Behaviour:
- Reset (sync, active-high):
  - Sampled at posedge. The cycle after, all pointers, counts and sticky flags are 0.
  - pndng=0, D_pop=0, tx_full=0, rx_vld=0, rd_data=0, misroute_cnt=0.
  - Reset mid-operation discards all FIFO contents.
  - pop/push/wr_en/rd_en are ignored during the reset cycle.
- TX FIFO (circular buffer, wr_ptr/rd_ptr wrap modulo depth, separate count):
  - pndng = (tx_cnt!=0); tx_full = (tx_cnt==depth). Both are derived from registered count, so they update the cycle after the causing edge.
  - D_pop = mem[rd_ptr] when pndng=1, else 0. It is stable while pndng=1 and no pop occurs.
  - pop with pndng=1: rd_ptr advances at the edge, and the next D_pop is valid the following cycle.
  - pop with pndng=0 is ignored: no pointer or count change.
  - wr_en with tx_full=0: entry stored, count+1.
  - wr_en with tx_full=1 and no pop: dropped, tx_ovf<=1 (sticky until reset).
  - wr_en and pop in the same cycle with TX non-empty (including full): both take effect, count unchanged.
  - wr_en and pop with TX empty: pop ignored, write accepted, count 0->1.
  - Latency from host write to pndng=1 is 1 cycle.
- RX path:
  - On push, dest = D_push[pckg_sz-1 -: 8].
  - dest==dev_id or dest==broadcast: accepted and stored. If the RX FIFO is full and rd_en is not active, the packet is dropped and rx_ovf<=1.
  - Any other dest: not stored; misroute_cnt increments, saturating at 255.
  - rx_vld = (rx_cnt!=0). rd_data = head when rx_vld, else 0.
  - rd_en with rx_vld=0 is ignored.
  - push (accepted) and rd_en in the same cycle with RX full: both take effect, count unchanged, no overflow.
  - Latency from push to rx_vld=1 is 1 cycle.
- TX and RX are fully independent. Simultaneous pop and push to the same device in one cycle are both honoured.
- Arithmetic: counts are $clog2(depth)+1 bits wide and are never allowed to exceed depth or underflow.

Test Plan:
- After reset, host writes 16'h0311, 16'h0322 in consecutive cycles -> pndng=1 one cycle after the first write; D_pop=16'h0311. After one pop, D_pop=16'h0322 and tx_cnt=1. After a second pop, pndng=0 and D_pop=0.
- Nine writes (depth=8) with no pops -> tx_full=1 after the 8th, the 9th is dropped, tx_ovf=1, tx_cnt=8. Then 8 pops return the first eight values in order, exercising pointer wrap.
- TX full, same-cycle wr_en=16'h01AA and pop -> tx_cnt stays 8, tx_ovf stays 0. 16'h01AA is the last entry drained.
- dev_id=2: push 16'h0255, 16'hFF66, 16'h0377 -> RX holds 16'h0255 then 16'hFF66, rx_cnt=2, misroute_cnt=1.
- Fill RX with 8 accepted packets, then push a 9th -> rx_ovf=1, rx_cnt=8. Repeat with rd_en in the same cycle as the 9th push -> accepted, no overflow.
- Reset asserted while tx_cnt=5 and rx_cnt=3 -> next cycle pndng=0, rx_vld=0, all counts and flags 0. A subsequent write behaves as the first write after power-up.
